// File: rtl/sound_event_scheduler_pkg.sv
// Shared types and constants for the sound event scheduler.
// Source indices, tone divisors and priority helpers.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  localparam int SRC_BAD  = 2;
  localparam int SRC_GOOD = 1;
  localparam int SRC_MOVE = 0;

  localparam logic [7:0] FREQ_BAD  = 8'd126;
  localparam logic [7:0] FREQ_GOOD = 8'd89;
  localparam logic [7:0] FREQ_MOVE = 8'd149;

  // one-hot of the highest-ranked set bit (bad > good > move)
  function automatic logic [2:0] pick_hi(input logic [2:0] p);
    logic [2:0] r;
    r = '0;
    if (p[SRC_BAD])
      r[SRC_BAD] = 1'b1;
    else if (p[SRC_GOOD])
      r[SRC_GOOD] = 1'b1;
    else if (p[SRC_MOVE])
      r[SRC_MOVE] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] freq_of(input logic [2:0] oh);
    logic [7:0] f;
    f = '0;
    unique case (1'b1)
      oh[SRC_BAD]:  f = FREQ_BAD;
      oh[SRC_GOOD]: f = FREQ_GOOD;
      oh[SRC_MOVE]: f = FREQ_MOVE;
      default:      f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sound_event_scheduler_tone_timer.sv
// Down-counter shared by tone and gap intervals.
// Loads on strobe, counts to zero and holds there.
module tone_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // load wins over counting; parks at zero
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/sound_event_scheduler.sv
// Fixed-priority arbiter of game sound events onto
// the single tone oscillator, with tone and gap timing.
module sound_event_scheduler
  import sound_pkg::*;
#(
  parameter int TONE_TICKS = 20,
  parameter int GAP_TICKS  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic [2:0] req_i,
  output logic [7:0] freq_o,
  output logic       play_o,
  output logic [2:0] active_o,
  output logic       busy_o
);

  localparam int MAXT =
    (TONE_TICKS > GAP_TICKS) ? TONE_TICKS : GAP_TICKS;
  localparam int TW = $clog2(MAXT + 1);
  localparam logic [TW-1:0] TONE_LOAD =
    TW'(TONE_TICKS - 1);
  localparam logic [TW-1:0] GAP_LOAD =
    (GAP_TICKS > 0) ? TW'(GAP_TICKS - 1) : '0;

  state_t        state, state_n;
  logic [2:0]    pending, pend_n;
  logic [7:0]    freq_n;
  logic          play_n;
  logic [2:0]    act_n;
  logic [2:0]    pick;
  logic          grant, go_idle;
  logic          tload, tdone;
  logic [TW-1:0] tval;

  tone_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tload),
    .load_val (tval),
    .done     (tdone)
  );

  // next state, pending latch, grant and output values
  always_comb begin
    state_n = state;
    pend_n  = pending | req_i;
    freq_n  = freq_o;
    play_n  = play_o;
    act_n   = active_o;
    tload   = 1'b0;
    tval    = '0;
    grant   = 1'b0;
    go_idle = 1'b0;
    pick    = pick_hi(pending);

    unique case (state)
      IDLE: grant = |pending;
      PLAY: begin
        if (pick > active_o)
          grant = 1'b1;
        else if (tdone) begin
          if (GAP_TICKS == 0) begin
            if (|pending) grant = 1'b1;
            else go_idle = 1'b1;
          end else begin
            state_n = GAP;
            tload   = 1'b1;
            tval    = GAP_LOAD;
            freq_n  = '0;
            play_n  = 1'b0;
            act_n   = '0;
          end
        end
      end
      GAP: begin
        if (tdone) begin
          if (|pending) grant = 1'b1;
          else go_idle = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (grant) begin
      state_n = PLAY;
      pend_n  = pend_n & ~pick;
      freq_n  = freq_of(pick);
      act_n   = pick;
      play_n  = 1'b1;
      tload   = 1'b1;
      tval    = TONE_LOAD;
    end

    if (go_idle) begin
      state_n = IDLE;
      freq_n  = '0;
      play_n  = 1'b0;
      act_n   = '0;
    end

    if (!enable_i) begin
      state_n = IDLE;
      pend_n  = '0;
      freq_n  = '0;
      play_n  = 1'b0;
      act_n   = '0;
      tload   = 1'b1;
      tval    = '0;
    end
  end

  // state, pending and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      freq_o   <= '0;
      play_o   <= 1'b0;
      active_o <= '0;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_n;
      pending  <= pend_n;
      freq_o   <= freq_n;
      play_o   <= play_n;
      active_o <= act_n;
      busy_o   <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed bench for sound_event_scheduler.
// Default build plus a zero-gap build side by side.
module tb_sound_event_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, en0;
  logic [2:0] req, req0;
  logic [7:0] freq, freq0;
  logic       play, play0;
  logic [2:0] act, act0;
  logic       busy, busy0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sound_event_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .enable_i (en),
    .req_i    (req),
    .freq_o   (freq),
    .play_o   (play),
    .active_o (act),
    .busy_o   (busy)
  );

  sound_event_scheduler #(
    .TONE_TICKS (20),
    .GAP_TICKS  (0)
  ) dut0 (
    .clk      (clk),
    .rst      (rst),
    .enable_i (en0),
    .req_i    (req0),
    .freq_o   (freq0),
    .play_o   (play0),
    .active_o (act0),
    .busy_o   (busy0)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(
    input logic       b,
    input logic       p,
    input logic [2:0] a,
    input logic [7:0] f
  );
    return {19'b0, b, p, a, f};
  endfunction

  function automatic logic [31:0] obs();
    return pk(busy, play, act, freq);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tone(
    input string      tag,
    input logic [2:0] a,
    input logic [7:0] f,
    input int         n
  );
    for (int i = 0; i < n; i++) begin
      chk(tag, obs(), pk(1'b1, 1'b1, a, f));
      tick();
    end
  endtask

  task automatic gap(input string tag);
    for (int i = 0; i < 5; i++) begin
      chk(tag, obs(), pk(1'b1, 1'b0, 3'b000, 8'd0));
      tick();
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, obs(), 32'd0);
      tick();
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    en0  = 1'b1;
    req  = '0;
    req0 = '0;
    tick();
    tick();
    chk("rst_init", obs(), 32'd0);
    chk("rst_init0", pk(busy0, play0, act0, freq0), 32'd0);
    rst = 1'b0;
    tick();

    // single good event with latency, length and gap
    req = 3'b010;
    tick();
    req = '0;
    chk("good_lat", obs(), 32'd0);
    tick();
    tone("good_tone", 3'b010, 8'd89, 20);
    gap("good_gap");
    idle("good_idle", 3);

    // simultaneous bad+move: bad first, move after gap
    req = 3'b101;
    tick();
    req = '0;
    tick();
    tone("sim_bad", 3'b100, 8'd126, 20);
    gap("sim_gap");
    tone("sim_move", 3'b001, 8'd149, 20);
    gap("sim_gap2");
    idle("sim_idle", 2);

    // preempt: bad interrupts move, good queues behind bad
    req = 3'b001;
    tick();
    req = '0;
    tick();
    tone("pre_move", 3'b001, 8'd149, 4);
    chk("pre_move5", obs(), pk(1, 1, 3'b001, 8'd149));
    req = 3'b100;
    tick();
    req = '0;
    chk("pre_move6", obs(), pk(1, 1, 3'b001, 8'd149));
    tick();
    tone("pre_bad", 3'b100, 8'd126, 3);
    chk("pre_bad4", obs(), pk(1, 1, 3'b100, 8'd126));
    req = 3'b010;
    tick();
    req = '0;
    tone("pre_bad_rest", 3'b100, 8'd126, 16);
    gap("pre_gap");
    tone("pre_good", 3'b010, 8'd89, 20);
    gap("pre_gap2");
    idle("pre_idle", 3);

    // reset mid-tone with good pending: no replay
    req = 3'b100;
    tick();
    req = '0;
    tick();
    tone("rst_bad", 3'b100, 8'd126, 3);
    req = 3'b010;
    tick();
    req = '0;
    rst = 1'b1;
    tick();
    chk("rst_mid", obs(), 32'd0);
    tick();
    rst = 1'b0;
    idle("rst_noreplay", 5);

    // disable mid-tone with good pending
    req = 3'b100;
    tick();
    req = '0;
    tick();
    tone("dis_bad", 3'b100, 8'd126, 3);
    req = 3'b010;
    tick();
    req = '0;
    en  = 1'b0;
    tick();
    chk("dis_off", obs(), 32'd0);
    req = 3'b001;
    tick();
    req = '0;
    chk("dis_ign", obs(), 32'd0);
    tick();
    en = 1'b1;
    idle("dis_reen", 5);

    // zero-gap build: back-to-back tones
    req0 = 3'b101;
    tick();
    req0 = '0;
    tick();
    for (int i = 0; i < 40; i++) begin
      chk("zg_tone", pk(busy0, play0, act0, freq0),
          (i < 20) ? pk(1, 1, 3'b100, 8'd126)
                   : pk(1, 1, 3'b001, 8'd149));
      tick();
    end
    chk("zg_idle", pk(busy0, play0, act0, freq0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
